// File: rtl/nios2_qsys_nios2_cpu_mul_combine_pkg.sv
// nios2_qsys_nios2_cpu_mul_combine_pkg: shared CPU widths used by the multiply cell
package nios2_qsys_nios2_cpu_mul_combine_pkg;
  localparam int REGNUM_W = 5;
  localparam int DATA_W = 32;
  localparam int HALF_W = 16;
endpackage

// File: rtl/nios2_qsys_nios2_cpu_mul_combine.sv
// nios2_qsys_nios2_cpu_mul_combine: folds 16x16 partial products into a 32-bit
// low product over the A and W pipeline stages, with hazard detect and completion count
module nios2_qsys_nios2_cpu_mul_combine
  import nios2_qsys_nios2_cpu_mul_combine_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   M_mul_cell_p1,
  input  logic [DATA_W-1:0]   M_mul_cell_p2,
  input  logic [DATA_W-1:0]   M_mul_cell_p3,
  input  logic                M_mul_valid,
  input  logic [REGNUM_W-1:0] M_dst_regnum,
  input  logic                A_en,
  input  logic                A_flush,
  input  logic [REGNUM_W-1:0] D_src1_regnum,
  input  logic [REGNUM_W-1:0] D_src2_regnum,
  output logic [DATA_W-1:0]   W_mul_result,
  output logic                W_mul_valid,
  output logic [REGNUM_W-1:0] W_mul_dst,
  output logic                mul_hazard,
  output logic [CNT_W-1:0]    mul_count
);
  logic [DATA_W-1:0] a_p1;
  logic [HALF_W-1:0] a_cross;
  logic [REGNUM_W-1:0] a_dst;
  logic a_valid;
  logic [HALF_W-1:0] m_cross;
  logic [DATA_W-1:0] a_result;
  logic unused_hi;
  // upper halves of the cross products only land above bit 31
  assign unused_hi = ^{M_mul_cell_p2[DATA_W-1:HALF_W], M_mul_cell_p3[DATA_W-1:HALF_W]};
  assign m_cross = M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0];
  assign a_result = a_p1 + {a_cross, {HALF_W{1'b0}}};
  function automatic logic hit(input logic v, input logic [REGNUM_W-1:0] d);
    return v && d != '0 && (d == D_src1_regnum || d == D_src2_regnum);
  endfunction
  assign mul_hazard = hit(a_valid, a_dst) || hit(W_mul_valid, W_mul_dst);
  // flush kills valids only; data registers keep their contents
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_p1 <= '0;
      a_cross <= '0;
      a_dst <= '0;
      a_valid <= 1'b0;
      W_mul_result <= '0;
      W_mul_dst <= '0;
      W_mul_valid <= 1'b0;
      mul_count <= '0;
    end else if (A_flush) begin
      a_valid <= 1'b0;
      W_mul_valid <= 1'b0;
    end else if (A_en) begin
      a_p1 <= M_mul_cell_p1;
      a_cross <= m_cross;
      a_dst <= M_dst_regnum;
      a_valid <= M_mul_valid;
      W_mul_result <= a_result;
      W_mul_dst <= a_dst;
      W_mul_valid <= a_valid;
      mul_count <= mul_count + CNT_W'(a_valid);
    end
endmodule

// File: tb/tb_nios2_qsys_nios2_cpu_mul_combine.sv
// tb_nios2_qsys_nios2_cpu_mul_combine: table vectors, corner sequences and random
// traffic checked against a product-level pipeline model
module tb_nios2_qsys_nios2_cpu_mul_combine;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [31:0] M_mul_cell_p1 = '0, M_mul_cell_p2 = '0, M_mul_cell_p3 = '0;
  logic M_mul_valid = 1'b0, A_en = 1'b0, A_flush = 1'b0;
  logic [4:0] M_dst_regnum = '0, D_src1_regnum = '0, D_src2_regnum = '0;
  logic [31:0] W_mul_result;
  logic W_mul_valid, mul_hazard;
  logic [4:0] W_mul_dst;
  logic [15:0] mul_count;

  nios2_qsys_nios2_cpu_mul_combine #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .M_mul_cell_p1(M_mul_cell_p1), .M_mul_cell_p2(M_mul_cell_p2), .M_mul_cell_p3(M_mul_cell_p3),
    .M_mul_valid(M_mul_valid), .M_dst_regnum(M_dst_regnum),
    .A_en(A_en), .A_flush(A_flush),
    .D_src1_regnum(D_src1_regnum), .D_src2_regnum(D_src2_regnum),
    .W_mul_result(W_mul_result), .W_mul_valid(W_mul_valid), .W_mul_dst(W_mul_dst),
    .mul_hazard(mul_hazard), .mul_count(mul_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic v; logic [4:0] d; logic [31:0] r;} slot_t;
  typedef struct {logic [31:0] p1, p2, p3; logic [4:0] dst; logic [31:0] exp;} vec_t;
  slot_t pipe[2];
  logic [15:0] m_cnt;
  logic [31:0] m_exp;
  int tests = 0, fails = 0;
  vec_t vec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_haz();
    logic h = 1'b0;
    foreach (pipe[i])
      if (pipe[i].v && pipe[i].d != 0 && (pipe[i].d == D_src1_regnum || pipe[i].d == D_src2_regnum)) h = 1'b1;
    return h;
  endfunction

  task automatic check_all();
    chk("w_valid", 32'(W_mul_valid), 32'(pipe[1].v));
    chk("count", 32'(mul_count), 32'(m_cnt));
    chk("hazard", 32'(mul_hazard), 32'(exp_haz()));
    if (pipe[1].v) begin
      chk("w_result", W_mul_result, pipe[1].r);
      chk("w_dst", 32'(W_mul_dst), 32'(pipe[1].d));
    end
  endtask

  task automatic model_reset();
    foreach (pipe[i]) pipe[i] = '{1'b0, 5'd0, 32'd0};
    m_cnt = '0;
  endtask

  task automatic cycle(input bit do_chk = 1'b1);
    @(posedge clk);
    if (!reset_n) model_reset();
    else if (A_flush) begin
      pipe[0].v = 1'b0;
      pipe[1].v = 1'b0;
    end else if (A_en) begin
      if (pipe[0].v) m_cnt = m_cnt + 16'd1;
      pipe[1] = pipe[0];
      pipe[0] = '{M_mul_valid, M_dst_regnum, m_exp};
    end
    #1;
    if (do_chk) check_all();
  endtask

  task automatic set_m(input logic [31:0] p1, p2, p3, input logic v, input logic [4:0] d, input logic [31:0] e);
    M_mul_cell_p1 = p1;
    M_mul_cell_p2 = p2;
    M_mul_cell_p3 = p3;
    M_mul_valid = v;
    M_dst_regnum = d;
    m_exp = e;
  endtask

  // partial products built from random operands; upper halves of p2/p3 are junk
  task automatic rand_m(input logic v, input logic [4:0] d);
    logic [31:0] s1, s2, x, y, p1;
    s1 = $urandom;
    s2 = $urandom;
    p1 = s1[15:0] * s2[15:0];
    x = s1[15:0] * s2[31:16];
    y = s1[31:16] * s2[15:0];
    set_m(p1, {16'($urandom), x[15:0]}, {16'($urandom), y[15:0]}, v, d, s1 * s2);
  endtask

  initial begin
    logic [15:0] c0;
    vec[0] = '{32'h0000F6E3, 32'h000069CF, 32'h00000007, 5'd3,  32'h69D6F6E3};
    vec[1] = '{32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 5'd31, 32'h00000001};
    vec[2] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h00000001, 5'd1,  32'hFFFFFFFF};
    vec[3] = '{32'h0000FFFF, 32'hABCD8000, 32'h12348000, 5'd0,  32'h0000FFFF};
    vec[4] = '{32'h80000000, 32'h00008000, 32'h00000000, 5'd17, 32'h00000000};
    model_reset();
    m_exp = '0;
    D_src1_regnum = 5'd0;
    D_src2_regnum = 5'd0;
    #12;
    chk("rst_valid", 32'(W_mul_valid), 32'd0);
    chk("rst_result", W_mul_result, 32'd0);
    chk("rst_dst", 32'(W_mul_dst), 32'd0);
    chk("rst_count", 32'(mul_count), 32'd0);
    chk("rst_hazard", 32'(mul_hazard), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    A_en = 1'b1;

    foreach (vec[i]) begin
      set_m(vec[i].p1, vec[i].p2, vec[i].p3, 1'b1, vec[i].dst, vec[i].exp);
      cycle();
      M_mul_valid = 1'b0;
      cycle();
      chk("vec_result", W_mul_result, vec[i].exp);
      chk("vec_dst", 32'(W_mul_dst), 32'(vec[i].dst));
      chk("vec_valid", 32'(W_mul_valid), 32'd1);
    end

    c0 = mul_count;
    set_m(32'h0000F6E3, 32'h000069CF, 32'h00000007, 1'b1, 5'd3, 32'h69D6F6E3);
    cycle();
    M_mul_valid = 1'b0;
    A_en = 1'b0;
    repeat (3) begin
      cycle();
      chk("stall_wvalid", 32'(W_mul_valid), 32'd0);
    end
    A_en = 1'b1;
    cycle();
    chk("stall_out_valid", 32'(W_mul_valid), 32'd1);
    chk("stall_out_result", W_mul_result, 32'h69D6F6E3);
    chk("stall_count", 32'(mul_count), 32'(c0 + 16'd1));

    rand_m(1'b1, 5'd4);
    cycle();
    rand_m(1'b1, 5'd5);
    cycle();
    c0 = mul_count;
    D_src1_regnum = 5'd4;
    D_src2_regnum = 5'd5;
    #1;
    chk("preflush_hazard", 32'(mul_hazard), 32'd1);
    rand_m(1'b1, 5'd6);
    A_flush = 1'b1;
    cycle();
    chk("flush_wvalid", 32'(W_mul_valid), 32'd0);
    chk("flush_hazard", 32'(mul_hazard), 32'd0);
    chk("flush_count", 32'(mul_count), 32'(c0));
    A_flush = 1'b0;
    M_mul_valid = 1'b0;
    cycle();
    chk("flush_no_capture", 32'(W_mul_valid), 32'd0);

    D_src1_regnum = 5'd0;
    D_src2_regnum = 5'd7;
    rand_m(1'b1, 5'd7);
    cycle();
    chk("haz_dst7", 32'(mul_hazard), 32'd1);
    D_src2_regnum = 5'd9;
    rand_m(1'b1, 5'd0);
    cycle();
    chk("haz_dst0", 32'(mul_hazard), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      rand_m(($urandom % 4) != 0, 5'($urandom % 8));
      A_en = ($urandom % 5) != 0;
      A_flush = ($urandom % 16) == 0;
      D_src1_regnum = 5'($urandom % 8);
      D_src2_regnum = 5'($urandom % 8);
      cycle();
    end
    A_en = 1'b1;
    A_flush = 1'b0;

    rand_m(1'b1, 5'd2);
    cycle();
    rand_m(1'b1, 5'd3);
    cycle();
    D_src1_regnum = 5'd2;
    D_src2_regnum = 5'd3;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(W_mul_valid), 32'd0);
    chk("midrst_result", W_mul_result, 32'd0);
    chk("midrst_dst", 32'(W_mul_dst), 32'd0);
    chk("midrst_count", 32'(mul_count), 32'd0);
    chk("midrst_hazard", 32'(mul_hazard), 32'd0);
    model_reset();
    @(negedge clk);
    set_m(32'h0000F6E3, 32'h000069CF, 32'h00000007, 1'b1, 5'd3, 32'h69D6F6E3);
    reset_n = 1'b1;
    cycle();
    M_mul_valid = 1'b0;
    cycle();
    chk("post_rst_valid", 32'(W_mul_valid), 32'd1);
    chk("post_rst_result", W_mul_result, 32'h69D6F6E3);

    set_m(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b1, 5'd1, 32'h00000001);
    while (m_cnt != 16'hFFFF) cycle(1'b0);
    check_all();
    chk("wrap_full", 32'(mul_count), 32'h0000FFFF);
    cycle();
    chk("wrap_zero", 32'(mul_count), 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nios2_qsys_nios2_cpu_mul_combine.md
NIOS2_QSYS_NIOS2_CPU_MUL_COMBINE -- requirements
Module: nios2_qsys_nios2_cpu_mul_combine

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-multiply counter.
REQ-002 SHALL have clk input, 1 bit: the only clock; every register is clocked on its rising edge.
REQ-003 SHALL have reset_n input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have M_mul_cell_p1 input, 32 bits: unsigned partial product src1[15:0]*src2[15:0].
REQ-005 SHALL have M_mul_cell_p2 input, 32 bits: unsigned partial product src1[15:0]*src2[31:16].
REQ-006 SHALL have M_mul_cell_p3 input, 32 bits: unsigned partial product src1[31:16]*src2[15:0].
REQ-007 SHALL have M_mul_valid input, 1 bit: the M-stage instruction is a multiply and p1..p3 are valid this cycle.
REQ-008 SHALL have M_dst_regnum input, 5 bits: destination register of the M-stage multiply.
REQ-009 SHALL have A_en input, 1 bit: pipeline advance; 0 means stall and hold all state.
REQ-010 SHALL have A_flush input, 1 bit: kill all in-flight multiplies.
REQ-011 SHALL have D_src1_regnum and D_src2_regnum inputs, 5 bits each: source registers of the decode-stage instruction.
REQ-012 SHALL have W_mul_result output, 32 bits: low 32 bits of the product.
REQ-013 SHALL have W_mul_valid output, 1 bit: W_mul_result and W_mul_dst are valid.
REQ-014 SHALL have W_mul_dst output, 5 bits: destination register of the W-stage result.
REQ-015 SHALL have mul_hazard output, 1 bit: a decode-stage source matches an in-flight multiply destination.
REQ-016 SHALL have mul_count output, CNT_W bits: number of completed multiplies.

Function
REQ-017 SHALL, in stage A, register p1, cross = (p2[15:0] + p3[15:0]) mod 2^16, dst and valid = M_mul_valid on each cycle with A_en=1.
REQ-018 SHALL, in stage W, register result = (A_p1 + {A_cross, 16'h0}) mod 2^32, together with A_dst and A_valid, on each cycle with A_en=1.
REQ-019 SHALL have a latency of exactly 2 A_en=1 edges from M_mul_valid to W_mul_valid; cycles with A_en=0 add no bubbles and lose no data.
REQ-020 SHALL ignore p2[31:16] and p3[31:16]; carries beyond bit 31 SHALL be discarded.
REQ-021 SHALL, on A_flush=1, clear the A and W valid bits at the next edge regardless of A_en, leave the data registers unchanged, and not capture M_mul_valid that cycle; flush has priority over advance.
REQ-022 SHALL drive mul_hazard combinationally, asserted when (A_valid and A_dst is nonzero and matches either D source) or the same condition holds for W; regnum 0 SHALL never match.
REQ-023 SHALL increment mul_count by 1 on each edge where A_en=1, A_flush=0 and A_valid=1, wrapping from all-ones to 0.
REQ-024 SHALL, with back-to-back valid multiplies and A_en held at 1, produce one result per cycle in issue order.

Reset
REQ-025 SHALL, while reset_n=0, hold W_mul_valid=0, W_mul_result=0, W_mul_dst=0, mul_count=0, all A-stage registers at 0 and mul_hazard=0.
REQ-026 SHALL discard in-flight multiplies when reset asserts mid-operation, and SHALL accept M_mul_valid at the first rising edge after reset_n deasserts.

Structure
REQ-027 SHALL place REGNUM_W=5, DATA_W=32 and HALF_W=16 in the shared CPU package used by the multiply cell.
REQ-028 SHALL be a single flat module with no sub-modules; the two adders are inferred.

Verification
REQ-029 SHALL cover p1=0x0000F6E3, p2=0x000069CF, p3=0x00000007 (src 0x00012345*0x00030007), dst=3 -> two edges later W_mul_result=0x69D6F6E3, W_mul_dst=3, W_mul_valid=1.
REQ-030 SHALL cover p1=p2=p3=0xFFFE0001 (src 0xFFFFFFFF*0xFFFFFFFF) -> W_mul_result=0x00000001, proving cross and carry wrap.
REQ-031 SHALL cover a valid multiply followed by A_en=0 for 3 cycles -> A/W contents held, W_mul_valid appears only after the second A_en=1 edge, mul_count +1.
REQ-032 SHALL cover A_flush=1 with A_en=1 while A and W hold valid multiplies and M_mul_valid=1 -> next cycle both valids are 0 and mul_count is unchanged.
REQ-033 SHALL cover A_dst=7 valid with D_src2_regnum=7 -> mul_hazard=1; dst=0 with D_src1_regnum=0 -> mul_hazard=0.
REQ-034 SHALL cover mul_count preloaded to 0xFFFF by 65535 multiplies, plus one more completion -> mul_count=0x0000; reset_n pulsed low mid-pipeline -> all outputs 0 immediately.
